// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the round-robin bus arbiter.
// Define ARB_TIMEOUT_EN to abort BUSY transactions that never see s_ack.
package bus_arbiter_pkg;

  localparam int          DATA_W              = 32;
  localparam int          ARB_TIMEOUT_DEFAULT = 255;
  localparam logic [31:0] ARB_ABORT_RDATA     = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/bus_arbiter_if.sv
// Master-side request buses and the shared slave port of the arbiter.
// The arbiter attaches through the slave modport; the environment uses master.
interface bus_arbiter_if
  import bus_arbiter_pkg::*;
#(
  parameter int NM = 2,
  parameter int IW = 1
) ();

  logic [NM-1:0]        m_req;
  logic [NM-1:0]        m_rw;
  logic [NM*DATA_W-1:0] m_addr;
  logic [NM*DATA_W-1:0] m_wdata;
  logic [NM-1:0]        m_ack;
  logic [NM-1:0]        m_err;
  logic [DATA_W-1:0]    m_rdata;

  logic                 s_strobe;
  logic                 s_rw;
  logic [DATA_W-1:0]    s_addr;
  logic [DATA_W-1:0]    s_wdata;
  logic [DATA_W-1:0]    s_rdata;
  logic                 s_ack;

  logic                 busy;
  logic [IW-1:0]        gnt;

  modport slave (
    input  m_req, m_rw, m_addr, m_wdata, s_rdata, s_ack,
    output m_ack, m_err, m_rdata, s_strobe, s_rw, s_addr, s_wdata, busy, gnt
  );

  modport master (
    output m_req, m_rw, m_addr, m_wdata, s_rdata, s_ack,
    input  m_ack, m_err, m_rdata, s_strobe, s_rw, s_addr, s_wdata, busy, gnt
  );

endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate requests to start after `last`,
// priority-encode the lowest set bit, then map the offset back to an index.
module rr_pick #(
  parameter int NM = 2,
  parameter int IW = 1
) (
  input  logic [NM-1:0] req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] win,
  output logic          any
);

  logic [IW:0]   start;
  logic [IW:0]   sum;
  logic [NM-1:0] rot;
  logic [IW-1:0] off;

  always_comb begin
    start = {1'b0, last} + (IW+1)'(1);
    if (start >= (IW+1)'(NM)) begin
      start = '0;
    end
    // Doubling the vector lets a plain right shift act as a rotate.
    rot = NM'({req, req} >> start);
    off = '0;
    for (int k = NM - 1; k >= 0; k--) begin
      if (rot[k]) begin
        off = IW'(k);
      end
    end
    sum = {1'b0, off} + start;
    if (sum >= (IW+1)'(NM)) begin
      sum = sum - (IW+1)'(NM);
    end
    win = IW'(sum);
    any = |req;
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one slave port among NM masters, one access in flight.
// Optional feature: define ARB_TIMEOUT_EN to abort BUSY after TIMEOUT cycles without s_ack.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int NM      = 2,
  parameter int IW      = 1,
  parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  bus_arbiter_if.slave  bus
);

  if (NM < 2 || NM > 8 || IW != $clog2(NM) || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_cfg
    $error("bus_arbiter: illegal NM/IW/TIMEOUT combination");
  end

  arb_state_e        state_q, state_d;
  logic [IW-1:0]     gnt_q, gnt_d;
  logic [NM-1:0]     ack_q, ack_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [DATA_W-1:0] addr_arr  [NM];
  logic [DATA_W-1:0] wdata_arr [NM];
  logic [IW-1:0]     pick_win;
  logic              pick_any;
  logic              in_busy;
  logic              cur_rw;

  for (genvar gi = 0; gi < NM; gi++) begin : g_unpack
    assign addr_arr[gi]  = bus.m_addr[DATA_W*gi +: DATA_W];
    assign wdata_arr[gi] = bus.m_wdata[DATA_W*gi +: DATA_W];
  end

  rr_pick #(
    .NM (NM),
    .IW (IW)
  ) u_pick (
    .req  (bus.m_req),
    .last (gnt_q),
    .win  (pick_win),
    .any  (pick_any)
  );

  assign in_busy = (state_q == ARB_BUSY);
  assign cur_rw  = bus.m_rw[gnt_q];

`ifdef ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  logic [15:0]   cnt_q, cnt_d;
  logic [NM-1:0] err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    rdata_d = rdata_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = '0;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          state_d = ARB_BUSY;
          gnt_d   = pick_win;
`ifdef ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ARB_BUSY: begin
        // s_ack takes priority over a coinciding timeout.
        if (bus.s_ack) begin
          state_d        = ARB_DONE;
          ack_d[gnt_q]   = 1'b1;
          rdata_d        = cur_rw ? '0 : bus.s_rdata;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          state_d        = ARB_DONE;
          ack_d[gnt_q]   = 1'b1;
          err_d[gnt_q]   = 1'b1;
          rdata_d        = ARB_ABORT_RDATA;
        end else begin
          cnt_d          = cnt_q + 16'd1;
        end
`endif
      end
      ARB_DONE: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      gnt_q   <= IW'(NM - 1);
      ack_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign bus.m_err = err_q;
`else
  assign bus.m_err = '0;
`endif

  // Slave-side outputs are gated so nothing leaks onto the bus outside BUSY.
  assign bus.s_strobe = in_busy;
  assign bus.s_rw     = in_busy & cur_rw;
  assign bus.s_addr   = in_busy ? addr_arr[gnt_q]  : '0;
  assign bus.s_wdata  = in_busy ? wdata_arr[gnt_q] : '0;

  assign bus.m_ack   = ack_q;
  assign bus.m_rdata = rdata_q;
  assign bus.busy    = (state_q != ARB_IDLE);
  assign bus.gnt     = gnt_q;

endmodule
